// File: rtl/axi_mem_if_pkg.sv
// Shared AXI memory-interface definitions:
// burst types, response codes and controller states.
package axi_mem_if_pkg;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DRAIN,
    RESP
  } state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat word address for FIXED/INCR/WRAP bursts.
// Ports: addr, len, burst in; next_addr out (combinational).
module axi_burst_addr_gen
  import axi_mem_if_pkg::*;
#(
  parameter int AW = 13
) (
  input  logic [AW-1:0] addr,
  input  logic [7:0]    len,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr
);

  logic [AW-1:0] inc;
  logic [AW-1:0] mask;

  assign inc  = addr + AW'(1);
  // WRAP lengths are 2^n-1, so len doubles as the wrap mask
  assign mask = AW'(len);

  always_comb begin
    next_addr = addr;
    case (burst)
      FIXED:   next_addr = addr;
      INCR:    next_addr = inc;
      WRAP:    next_addr = (addr & ~mask) | (inc & mask);
      default: next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_write_burst_ctrl.sv
// AXI4 write bursts -> single-beat SRAM writes via grant/valid.
// Ports: AXI AW/W/B channels, MEM_* SRAM port, grant_i/valid_o.
module axi_write_burst_ctrl
  import axi_mem_if_pkg::*;
#(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_WDATA_WIDTH   = 64,
  parameter int AXI4_ID_WIDTH      = 16,
  parameter int AXI4_USER_WIDTH    = 10,
  parameter int AXI_NUMBYTES       = AXI4_WDATA_WIDTH / 8,
  parameter int MEM_ADDR_WIDTH     = 13,
  parameter int CHECK_RANGE        = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [AXI4_ID_WIDTH-1:0]      AWID_i,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] AWADDR_i,
  input  logic [7:0]                    AWLEN_i,
  input  logic [2:0]                    AWSIZE_i,
  input  logic [1:0]                    AWBURST_i,
  input  logic                          AWLOCK_i,
  input  logic [3:0]                    AWCACHE_i,
  input  logic [2:0]                    AWPROT_i,
  input  logic [3:0]                    AWREGION_i,
  input  logic [AXI4_USER_WIDTH-1:0]    AWUSER_i,
  input  logic [3:0]                    AWQOS_i,
  input  logic                          AWVALID_i,
  output logic                          AWREADY_o,
  input  logic [AXI4_WDATA_WIDTH-1:0]   WDATA_i,
  input  logic [AXI_NUMBYTES-1:0]       WSTRB_i,
  input  logic                          WLAST_i,
  input  logic [AXI4_USER_WIDTH-1:0]    WUSER_i,
  input  logic                          WVALID_i,
  output logic                          WREADY_o,
  output logic [AXI4_ID_WIDTH-1:0]      BID_o,
  output logic [1:0]                    BRESP_o,
  output logic                          BVALID_o,
  output logic [AXI4_USER_WIDTH-1:0]    BUSER_o,
  input  logic                          BREADY_i,
  output logic                          MEM_CEN_o,
  output logic                          MEM_WEN_o,
  output logic [MEM_ADDR_WIDTH-1:0]     MEM_A_o,
  output logic [AXI4_WDATA_WIDTH-1:0]   MEM_D_o,
  output logic [AXI_NUMBYTES-1:0]       MEM_BE_o,
  input  logic [AXI4_WDATA_WIDTH-1:0]   MEM_Q_i,
  input  logic                          grant_i,
  output logic                          valid_o
);

  localparam int OFFSET_BIT = $clog2(AXI_NUMBYTES);
  localparam int TOP        = MEM_ADDR_WIDTH + OFFSET_BIT;

  state_t                       cs;
  logic [AXI4_ID_WIDTH-1:0]     id_q;
  logic [AXI4_USER_WIDTH-1:0]   user_q;
  logic [MEM_ADDR_WIDTH-1:0]    addr_q;
  logic [MEM_ADDR_WIDTH-1:0]    addr_nxt;
  logic [7:0]                   len_q;
  logic [7:0]                   cnt_q;
  logic [1:0]                   burst_q;
  logic [1:0]                   err_q;

  logic       aw_hs;
  logic       beat;
  logic       last;
  logic       range_err;
  logic       proto_err;
  logic [1:0] aw_err;
  logic       unused_ok;

  assign unused_ok = ^{AWLOCK_i, AWCACHE_i, AWPROT_i,
                       AWREGION_i, AWQOS_i, WUSER_i, MEM_Q_i};

  assign range_err = (CHECK_RANGE == 1) &&
                     ((AWADDR_i >> TOP) != '0);
  assign proto_err = (AWBURST_i == 2'b11) ||
                     (AWSIZE_i != 3'(OFFSET_BIT)) ||
                     ((AWBURST_i == WRAP) &&
                      !(AWLEN_i inside {8'd1, 8'd3, 8'd7, 8'd15}));
  assign aw_err = range_err ? DECERR :
                  proto_err ? SLVERR : OKAY;

  // RESP also accepts AW so bursts can run back-to-back
  assign AWREADY_o = (cs == IDLE) || ((cs == RESP) && BREADY_i);
  assign aw_hs     = AWVALID_i && AWREADY_o;
  assign last      = (cnt_q == len_q);

  assign MEM_WEN_o = 1'b0;
  assign MEM_A_o   = addr_q;
  assign MEM_D_o   = WDATA_i;
  assign MEM_BE_o  = WSTRB_i;
  assign BID_o     = id_q;
  assign BUSER_o   = user_q;

  always_comb begin
    WREADY_o  = 1'b0;
    valid_o   = 1'b0;
    MEM_CEN_o = 1'b1;
    BVALID_o  = 1'b0;
    BRESP_o   = OKAY;
    beat      = 1'b0;
    case (cs)
      WRITE: begin
        valid_o   = WVALID_i;
        WREADY_o  = grant_i;
        beat      = WVALID_i && grant_i;
        MEM_CEN_o = ~beat;
      end
      DRAIN: begin
        WREADY_o = 1'b1;
        beat     = WVALID_i;
      end
      RESP: begin
        BVALID_o = 1'b1;
        BRESP_o  = err_q;
      end
      default: ;
    endcase
  end

  axi_burst_addr_gen #(
    .AW(MEM_ADDR_WIDTH)
  ) u_addr_gen (
    .addr     (addr_q),
    .len      (len_q),
    .burst    (burst_q),
    .next_addr(addr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs      <= IDLE;
      id_q    <= '0;
      user_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      burst_q <= '0;
      err_q   <= OKAY;
    end else if (aw_hs) begin
      id_q    <= AWID_i;
      user_q  <= AWUSER_i;
      addr_q  <= AWADDR_i[TOP-1:OFFSET_BIT];
      len_q   <= AWLEN_i;
      burst_q <= AWBURST_i;
      cnt_q   <= '0;
      err_q   <= aw_err;
      cs      <= (aw_err == OKAY) ? WRITE : DRAIN;
    end else begin
      case (cs)
        WRITE: begin
          if (beat) begin
            cnt_q  <= cnt_q + 8'd1;
            addr_q <= addr_nxt;
            if (WLAST_i != last) err_q <= SLVERR;
            if (last) cs <= RESP;
          end
        end
        DRAIN: begin
          if (beat) begin
            cnt_q <= cnt_q + 8'd1;
            if (last) cs <= RESP;
          end
        end
        RESP: begin
          if (BREADY_i) cs <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule
